// File: rtl/utils_pkg.sv
// Shared types, clock constants and button-arbitration helpers for the pacman board front end.
// Button vectors are always ordered {up, down, left, right}.
package utils_pkg;

  typedef enum logic [2:0] {IDLE, LEFT, RIGHT, UP, DOWN} direction_t;

  localparam int CLOCK_FREQ           = 25_000_000;
  localparam int DEBOUNCE_MS          = 10;
  localparam int DEBOUNCE_CYCLES_DFLT = CLOCK_FREQ / 1000 * DEBOUNCE_MS;

  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  typedef logic [3:0] btn_vec_t;

  // Fixed priority UP > LEFT > DOWN > RIGHT; IDLE when nothing is set.
  function automatic direction_t highest_priority(input btn_vec_t v);
    if (v[BTN_UP])         return UP;
    else if (v[BTN_LEFT])  return LEFT;
    else if (v[BTN_DOWN])  return DOWN;
    else if (v[BTN_RIGHT]) return RIGHT;
    else                   return IDLE;
  endfunction

  function automatic logic dir_held(input direction_t d, input btn_vec_t v);
    case (d)
      UP:      return v[BTN_UP];
      DOWN:    return v[BTN_DOWN];
      LEFT:    return v[BTN_LEFT];
      RIGHT:   return v[BTN_RIGHT];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, polarity normalisation (1 = pressed) and a stable-count debouncer.
module button_debouncer
  import utils_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic pressed
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            RELEASED = BTN_ACTIVE_LOW;

  logic [1:0]       sync_q;
  logic             s;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign s = sync_q[1] ^ BTN_ACTIVE_LOW;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = s;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{RELEASED}};
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pressed = deb_q;

endmodule

// File: rtl/direction_input_controller.sv
// Four debounced buttons -> newest-press-wins direction_t command with a change strobe.
// Define HOLD_LAST_DIR_EN to keep the last direction when every button is released.
module direction_input_controller
  import utils_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       pause,
  input  logic       restart,
  output direction_t dir_controller,
  output logic       dir_change,
  output logic [3:0] btn_pressed
);

  btn_vec_t   raw;
  btn_vec_t   held;
  btn_vec_t   held_prev_q, held_prev_d;
  btn_vec_t   press_edge;
  direction_t dir_q, dir_d;
  logic       dir_change_q, dir_change_d;

  assign raw = {btn_up, btn_down, btn_left, btn_right};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_debouncer (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (raw[i]),
      .pressed (held[i])
    );
  end

  // Edges are taken against last cycle's debounced state, so a pause simply lets them expire.
  always_comb begin
    held_prev_d = held;
    press_edge  = held & ~held_prev_q;
    dir_d       = dir_q;
    if (restart) begin
      dir_d = IDLE;
    end else if (!pause) begin
      if (press_edge != '0) begin
        dir_d = highest_priority(press_edge);
      end else if (!dir_held(dir_q, held)) begin
        if (held != '0) begin
          dir_d = highest_priority(held);
        end else begin
`ifdef HOLD_LAST_DIR_EN
          dir_d = dir_q;
`else
          dir_d = IDLE;
`endif
        end
      end
    end
    dir_change_d = (dir_d != dir_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_prev_q  <= '0;
      dir_q        <= IDLE;
      dir_change_q <= 1'b0;
    end else begin
      held_prev_q  <= held_prev_d;
      dir_q        <= dir_d;
      dir_change_q <= dir_change_d;
    end
  end

  assign dir_controller = dir_q;
  assign dir_change     = dir_change_q;
  assign btn_pressed    = held;

endmodule

// File: tb/tb_direction_input_controller.sv
// Bench for direction_input_controller: directed scenarios then random button activity, every cycle
// compared against a window-based debounce model and a rule-list arbitration model.
module tb_direction_input_controller;
  import utils_pkg::*;

  localparam int DC = 4;
  localparam int HN = DC + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       pause = 1'b0, restart = 1'b0;
  direction_t dir_controller;
  logic       dir_change;
  logic [3:0] btn_pressed;

  int errors = 0;
  int checks = 0;

  direction_input_controller #(
    .DEBOUNCE_CYCLES (DC),
    .BTN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .pause          (pause),
    .restart        (restart),
    .dir_controller (dir_controller),
    .dir_change     (dir_change),
    .btn_pressed    (btn_pressed)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples per edge (index 0 = this edge), debounced levels, direction.
  logic [3:0] hist [HN];
  logic [3:0] m_deb, m_deb_prev;
  direction_t m_dir;
  logic       m_change;

  direction_t prio_dir [4] = '{UP, LEFT, DOWN, RIGHT};
  int         prio_bit [4] = '{3, 1, 2, 0};

  function automatic direction_t first_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[prio_bit[i]]) return prio_dir[i];
    return IDLE;
  endfunction

  function automatic logic is_held(input direction_t d, input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (prio_dir[i] == d) return v[prio_bit[i]];
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < HN; i++) hist[i] = 4'b0000;
    m_deb      = 4'b0000;
    m_deb_prev = 4'b0000;
    m_dir      = IDLE;
    m_change   = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] deb_new;
    logic [3:0] edges;
    logic       stable;
    direction_t nxt;
    for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {btn_up, btn_down, btn_left, btn_right};
    // Synchronised view lags raw by two edges; level flips once DC synced samples all disagree with it.
    deb_new = m_deb;
    for (int b = 0; b < 4; b++) begin
      stable = 1'b1;
      for (int k = 2; k < HN; k++)
        if (hist[k][b] != hist[2][b]) stable = 1'b0;
      if (stable && hist[2][b] != m_deb[b]) deb_new[b] = hist[2][b];
    end
    edges = m_deb & ~m_deb_prev;
    nxt   = m_dir;
    if (restart) nxt = IDLE;
    else if (!pause) begin
      if (edges != 4'b0000) nxt = first_of(edges);
      else if (!is_held(m_dir, m_deb)) begin
        if (m_deb != 4'b0000) nxt = first_of(m_deb);
        else begin
`ifdef HOLD_LAST_DIR_EN
          nxt = m_dir;
`else
          nxt = IDLE;
`endif
        end
      end
    end
    m_change   = (nxt != m_dir);
    m_dir      = nxt;
    m_deb_prev = m_deb;
    m_deb      = deb_new;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    else         model_reset();
    #1;
    check("dir", 8'(dir_controller), 8'(m_dir));
    check("dir_change", 8'(dir_change), 8'(m_change));
    check("btn_pressed", 8'(btn_pressed), 8'(m_deb));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_btns(input logic [3:0] v);
    {btn_up, btn_down, btn_left, btn_right} = v;
  endtask

  task automatic count_until(input direction_t target, input int max_edges,
                             output int n_edges, output int n_changes);
    n_edges   = 0;
    n_changes = 0;
    while (dir_controller !== target && n_edges < max_edges) begin
      tick();
      n_edges++;
      if (dir_change) n_changes++;
    end
  endtask

  task automatic clear_all();
    set_btns(4'b0000);
    ticks(8);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
  endtask

  initial begin
    int         n_edges, n_chg;
    logic [3:0] v;
    int         b;

    model_reset();
    ticks(3);
    check("reset_dir", 8'(dir_controller), 8'(IDLE));
    check("reset_pressed", 8'(btn_pressed), 8'h00);
    reset_n = 1'b1;

    // 1: async reset mid-count, then recovery with LEFT held.
    set_btns(4'b1000);
    ticks(10);
    check("t1_up", 8'(dir_controller), 8'(UP));
    set_btns(4'b0010);
    ticks(3);
    reset_n = 1'b0;
    #2;
    check("t1_async_dir", 8'(dir_controller), 8'(IDLE));
    check("t1_async_chg", 8'(dir_change), 8'h00);
    check("t1_async_pressed", 8'(btn_pressed), 8'h00);
    model_reset();
    tick();
    reset_n = 1'b1;
    count_until(LEFT, 20, n_edges, n_chg);
    check("t1_latency", 8'(n_edges), 8'd7);
    check("t1_pulses", 8'(n_chg), 8'd1);

    // 2: bounce on UP, then a clean rise.
    clear_all();
    n_chg = 0;
    for (int i = 0; i < 20; i++) begin
      btn_up = ((i / 2) % 2 == 0);
      tick();
      if (dir_change) n_chg++;
    end
    check("t2_quiet", 8'(n_chg), 8'd0);
    btn_up = 1'b1;
    count_until(UP, 20, n_edges, n_chg);
    check("t2_latency", 8'(n_edges), 8'd7);
    check("t2_pulses", 8'(n_chg), 8'd1);

    // 3: newest press wins, release falls back to a held button.
    clear_all();
    set_btns(4'b0010); ticks(10);
    check("t3_left", 8'(dir_controller), 8'(LEFT));
    set_btns(4'b1010); ticks(10);
    check("t3_up", 8'(dir_controller), 8'(UP));
    set_btns(4'b0010); ticks(10);
    check("t3_back_left", 8'(dir_controller), 8'(LEFT));
    set_btns(4'b0000); ticks(10);
`ifdef HOLD_LAST_DIR_EN
    check("t3_release", 8'(dir_controller), 8'(LEFT));
`else
    check("t3_release", 8'(dir_controller), 8'(IDLE));
`endif

    // 4: simultaneous presses resolve by priority; a press beats a same-cycle release.
    clear_all();
    set_btns(4'b1100); ticks(10);
    check("t4_up_down", 8'(dir_controller), 8'(UP));
    clear_all();
    set_btns(4'b0011); ticks(10);
    check("t4_left_right", 8'(dir_controller), 8'(LEFT));
    set_btns(4'b0101); ticks(10);
    check("t4_down", 8'(dir_controller), 8'(DOWN));

    // 5: pause freezes the output while debouncing continues.
    clear_all();
    pause = 1'b1;
    set_btns(4'b0001);
    n_chg = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dir_change) n_chg++;
    end
    check("t5_hold", 8'(dir_controller), 8'(IDLE));
    check("t5_no_pulse", 8'(n_chg), 8'd0);
    check("t5_pressed", 8'(btn_pressed), 8'b0001);
    pause = 1'b0;
    tick();
    check("t5_right", 8'(dir_controller), 8'(RIGHT));
    check("t5_pulse", 8'(dir_change), 8'd1);

    // 6: restart clears, held button re-selects next cycle; restart overrides pause.
    set_btns(4'b1000); ticks(10);
    restart = 1'b1; tick(); restart = 1'b0;
    check("t6_idle", 8'(dir_controller), 8'(IDLE));
    check("t6_idle_pulse", 8'(dir_change), 8'd1);
    tick();
    check("t6_up", 8'(dir_controller), 8'(UP));
    check("t6_up_pulse", 8'(dir_change), 8'd1);
    restart = 1'b1; pause = 1'b1; tick(); restart = 1'b0; pause = 1'b0;
    check("t6_restart_pause", 8'(dir_controller), 8'(IDLE));
    tick();

    // Random activity: slow button changes, occasional pause toggles and restart pulses.
    v = 4'b0000;
    set_btns(v);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        b = int'($urandom_range(3));
        v = v ^ (4'b0001 << b);
        set_btns(v);
      end
      if ($urandom_range(29) == 0) pause = ~pause;
      restart = ($urandom_range(99) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
